load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/load_store_unit.sv | 144 ++++++++++++++
 tb/tb_load_store_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access size encoding, FSM states
// and the alignment check used at request acceptance.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_ILL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_e;

  // True for an illegal size or an access that straddles its natural alignment.
  function automatic logic req_error(input size_e size, input logic [1:0] addr_lo);
    logic err;
    case (size)
      SIZE_B:  err = 1'b0;
      SIZE_H:  err = addr_lo[0];
      SIZE_W:  err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extract/extend a load lane from a memory word
// and merge store data into a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_rd_word,
  input  logic [DATA_WIDTH-1:0] i_merge_word,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [1:0]            i_lane,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic [DATA_WIDTH-1:0] o_merge_data
);

  logic [4:0]            shamt;
  logic [DATA_WIDTH-1:0] lane_word;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] shifted_mask;

  always_comb begin
    shamt     = {i_lane, 3'b000};
    lane_word = i_rd_word >> shamt;

    o_load_data = lane_word;
    lane_mask   = '1;
    case (size_e'(i_size))
      SIZE_B: begin
        o_load_data = {{(DATA_WIDTH-8){~i_unsigned & lane_word[7]}}, lane_word[7:0]};
        lane_mask   = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
      end
      SIZE_H: begin
        o_load_data = {{(DATA_WIDTH-16){~i_unsigned & lane_word[15]}}, lane_word[15:0]};
        lane_mask   = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
      end
      default: begin
        o_load_data = lane_word;
        lane_mask   = '1;
      end
    endcase

    // Word accesses are always aligned here, so shamt is 0 and the merge is a plain overwrite.
    shifted_mask = lane_mask << shamt;
    o_merge_data = (i_merge_word & ~shifted_mask) | ((i_wdata & lane_mask) << shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of a word-wide memory with a
// combinational read port; sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [1:0]            i_req_size,
  input  logic                  i_req_unsigned,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [DATA_WIDTH-1:0] o_resp_rdata,
  output logic                  o_resp_err,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  state_e                state_q, state_d;
  logic                  we_q, we_d;
  size_e                 size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;

  lsu_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_lane_align (
    .i_rd_word   (i_mem_rdata),
    .i_merge_word(word_q),
    .i_wdata     (wdata_q),
    .i_size      (size_q),
    .i_unsigned  (uns_q),
    .i_lane      (addr_q[1:0]),
    .o_load_data (load_data),
    .o_merge_data(merge_data)
  );

  assign o_mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    word_d  = word_q;

    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_resp_rdata = '0;
    o_resp_err   = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_wdata  = '0;

    case (state_q)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          we_d    = i_req_we;
          size_d  = size_e'(i_req_size);
          uns_d   = i_req_unsigned;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          err_d   = req_error(size_e'(i_req_size), i_req_addr[1:0]);
          rdata_d = '0;
          if (req_error(size_e'(i_req_size), i_req_addr[1:0])) begin
            state_d = RESP;
          end else if (i_req_we && (size_e'(i_req_size) == SIZE_W)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          word_d  = i_mem_rdata;
          state_d = WRITE;
        end else begin
          rdata_d = load_data;
          state_d = RESP;
        end
      end
      WRITE: begin
        o_mem_we    = 1'b1;
        o_mem_wdata = (size_q == SIZE_W) ? wdata_q : merge_data;
        state_d     = RESP;
      end
      RESP: begin
        o_resp_valid = 1'b1;
        o_resp_rdata = rdata_q;
        o_resp_err   = err_q;
        if (i_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SIZE_B;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  logic        clk;
  logic        arstn;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [63:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;
  logic        o_mem_we;
  logic [63:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;

  logic [31:0] mem [0:63];
  logic        mem_clr;
  int          we_cnt;
  int          total;
  int          bad;

  load_store_unit #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(64)
  ) dut (
    .clk           (clk),
    .arstn         (arstn),
    .i_req_valid   (i_req_valid),
    .o_req_ready   (o_req_ready),
    .i_req_we      (i_req_we),
    .i_req_size    (i_req_size),
    .i_req_unsigned(i_req_unsigned),
    .i_req_addr    (i_req_addr),
    .i_req_wdata   (i_req_wdata),
    .o_resp_valid  (o_resp_valid),
    .i_resp_ready  (i_resp_ready),
    .o_resp_rdata  (o_resp_rdata),
    .o_resp_err    (o_resp_err),
    .o_mem_we      (o_mem_we),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .i_mem_rdata   (i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign i_mem_rdata = mem[o_mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= '0;
      we_cnt <= 0;
    end else if (o_mem_we) begin
      mem[o_mem_addr[7:2]] <= o_mem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  // Drive a request at a negedge with the DUT idle; return at the first negedge with a response.
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [63:0] addr, input logic [31:0] wdata, output int lat);
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_size     = size;
    i_req_unsigned = uns;
    i_req_addr     = addr;
    i_req_wdata    = wdata;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    lat = 1;
    while (!o_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic complete();
    i_resp_ready = 1'b1;
    @(negedge clk);
    i_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%0b exp=1", o_req_ready); end
    total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%0b exp=0", o_resp_valid); end
    total++; if (o_resp_err !== 1'b0) begin bad++; $display("FAIL reset_resp_err got=%0b exp=0", o_resp_err); end
    total++; if (o_resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_resp_rdata got=%h exp=0", o_resp_rdata); end
    total++; if (o_mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0b exp=0", o_mem_we); end
    total++; if (o_mem_addr !== 64'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", o_mem_addr); end
    total++; if (o_mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata got=%h exp=0", o_mem_wdata); end
    arstn = 1'b1;
    mem_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_store_load();
    int lat;
    int w0;
    w0 = we_cnt;
    send(1'b1, 2'b10, 1'b0, 64'h10, 32'hDEADBEEF, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL wst_latency got=%0d exp=2", lat); end
    total++; if (o_resp_err !== 1'b0) begin bad++; $display("FAIL wst_err got=%0b exp=0", o_resp_err); end
    total++; if (o_resp_rdata !== 32'h0) begin bad++; $display("FAIL wst_rdata got=%h exp=0", o_resp_rdata); end
    complete();
    total++; if (we_cnt - w0 !== 1) begin bad++; $display("FAIL wst_we_pulses got=%0d exp=1", we_cnt - w0); end
    total++; if (mem[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL wst_mem got=%h exp=deadbeef", mem[4]); end
    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL wst_ready_after got=%0b exp=1", o_req_ready); end
    send(1'b0, 2'b10, 1'b0, 64'h10, 32'h0, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL wld_latency got=%0d exp=2", lat); end
    total++; if (o_resp_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wld_rdata got=%h exp=deadbeef", o_resp_rdata); end
    total++; if (o_resp_err !== 1'b0) begin bad++; $display("FAIL wld_err got=%0b exp=0", o_resp_err); end
    complete();
  endtask

  task automatic test_byte_store();
    int lat;
    int w0;
    send(1'b1, 2'b10, 1'b0, 64'h10, 32'h11223344, lat);
    complete();
    w0 = we_cnt;
    send(1'b1, 2'b00, 1'b0, 64'h12, 32'h123456AA, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL bst_latency got=%0d exp=3", lat); end
    total++; if (o_resp_err !== 1'b0) begin bad++; $display("FAIL bst_err got=%0b exp=0", o_resp_err); end
    complete();
    total++; if (we_cnt - w0 !== 1) begin bad++; $display("FAIL bst_we_pulses got=%0d exp=1", we_cnt - w0); end
    total++; if (mem[4] !== 32'h11AA3344) begin bad++; $display("FAIL bst_mem got=%h exp=11aa3344", mem[4]); end
  endtask

  task automatic test_loads();
    logic [1:0]  sz  [9];
    logic        un  [9];
    logic [63:0] ad  [9];
    logic [31:0] ex  [9];
    int lat;
    sz = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    un = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
    ad = '{64'h12, 64'h12, 64'h12, 64'h10, 64'h11, 64'h16, 64'h16, 64'h17, 64'h14};
    ex = '{32'hFFFFFFAA, 32'h000000AA, 32'h000011AA, 32'h00003344, 32'h00000033,
           32'hFFFFBEEF, 32'h0000BEEF, 32'hFFFFFFBE, 32'h00000000};
    // Word 0x14 starts cleared; a half store fills its upper lane.
    send(1'b1, 2'b01, 1'b0, 64'h16, 32'h0000BEEF, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL hst_latency got=%0d exp=3", lat); end
    complete();
    total++; if (mem[5] !== 32'hBEEF0000) begin bad++; $display("FAIL hst_mem got=%h exp=beef0000", mem[5]); end
    for (int i = 0; i < 9; i++) begin
      send(1'b0, sz[i], un[i], ad[i], 32'h0, lat);
      total++; if (lat !== 2) begin bad++; $display("FAIL ld%0d_latency got=%0d exp=2", i, lat); end
      total++; if (o_resp_rdata !== ex[i]) begin bad++; $display("FAIL ld%0d_rdata got=%h exp=%h", i, o_resp_rdata, ex[i]); end
      complete();
    end
  endtask

  task automatic test_errors();
    logic        we  [5];
    logic [1:0]  sz  [5];
    logic [63:0] ad  [5];
    int lat;
    int w0;
    we = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    sz = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
    ad = '{64'h13, 64'h16, 64'h10, 64'h13, 64'h16};
    w0 = we_cnt;
    for (int i = 0; i < 5; i++) begin
      send(we[i], sz[i], 1'b0, ad[i], 32'hCAFEF00D, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL err%0d_latency got=%0d exp=1", i, lat); end
      total++; if (o_resp_err !== 1'b1) begin bad++; $display("FAIL err%0d_flag got=%0b exp=1", i, o_resp_err); end
      total++; if (o_resp_rdata !== 32'h0) begin bad++; $display("FAIL err%0d_rdata got=%h exp=0", i, o_resp_rdata); end
      complete();
    end
    total++; if (we_cnt - w0 !== 0) begin bad++; $display("FAIL err_we_pulses got=%0d exp=0", we_cnt - w0); end
    total++; if (mem[4] !== 32'h11AA3344) begin bad++; $display("FAIL err_mem4 got=%h exp=11aa3344", mem[4]); end
    total++; if (mem[5] !== 32'hBEEF0000) begin bad++; $display("FAIL err_mem5 got=%h exp=beef0000", mem[5]); end
  endtask

  task automatic test_resp_hold();
    int lat;
    int w0;
    w0 = we_cnt;
    send(1'b0, 2'b10, 1'b0, 64'h10, 32'h0, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL hold_latency got=%0d exp=2", lat); end
    // A competing store is offered the whole time the response is stalled.
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_size  = 2'b10;
    i_req_addr  = 64'h10;
    i_req_wdata = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (o_resp_valid !== 1'b1) begin bad++; $display("FAIL hold%0d_valid got=%0b exp=1", c, o_resp_valid); end
      total++; if (o_resp_rdata !== 32'h11AA3344) begin bad++; $display("FAIL hold%0d_rdata got=%h exp=11aa3344", c, o_resp_rdata); end
      total++; if (o_req_ready !== 1'b0) begin bad++; $display("FAIL hold%0d_ready got=%0b exp=0", c, o_req_ready); end
    end
    i_req_valid = 1'b0;
    complete();
    total++; if (we_cnt - w0 !== 0) begin bad++; $display("FAIL hold_we_pulses got=%0d exp=0", we_cnt - w0); end
    total++; if (mem[4] !== 32'h11AA3344) begin bad++; $display("FAIL hold_mem got=%h exp=11aa3344", mem[4]); end
  endtask

  task automatic test_back_to_back();
    int lat;
    send(1'b0, 2'b10, 1'b0, 64'h14, 32'h0, lat);
    // Offer the next request in the same cycle the response is consumed.
    i_resp_ready   = 1'b1;
    i_req_valid    = 1'b1;
    i_req_we       = 1'b0;
    i_req_size     = 2'b00;
    i_req_unsigned = 1'b0;
    i_req_addr     = 64'h12;
    @(negedge clk);
    i_resp_ready = 1'b0;
    total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL b2b_resp_done got=%0b exp=0", o_resp_valid); end
    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle_ready got=%0b exp=1", o_req_ready); end
    @(negedge clk);
    i_req_valid = 1'b0;
    total++; if (o_req_ready !== 1'b0) begin bad++; $display("FAIL b2b_accepted got=%0b exp=0", o_req_ready); end
    lat = 1;
    while (!o_resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++; if (lat !== 2) begin bad++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
    total++; if (o_resp_rdata !== 32'hFFFFFFAA) begin bad++; $display("FAIL b2b_rdata got=%h exp=ffffffaa", o_resp_rdata); end
    complete();
  endtask

  task automatic test_reset_in_write();
    int lat;
    int w0;
    w0 = we_cnt;
    i_req_valid    = 1'b1;
    i_req_we       = 1'b1;
    i_req_size     = 2'b00;
    i_req_unsigned = 1'b0;
    i_req_addr     = 64'h10;
    i_req_wdata    = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    total++; if (o_mem_we !== 1'b0) begin bad++; $display("FAIL rw_read_we got=%0b exp=0", o_mem_we); end
    @(negedge clk);
    total++; if (o_mem_we !== 1'b1) begin bad++; $display("FAIL rw_write_we got=%0b exp=1", o_mem_we); end
    total++; if (o_mem_wdata !== 32'h11AA3355) begin bad++; $display("FAIL rw_write_data got=%h exp=11aa3355", o_mem_wdata); end
    #2 arstn = 1'b0;
    #1;
    total++; if (o_mem_we !== 1'b0) begin bad++; $display("FAIL rw_async_we got=%0b exp=0", o_mem_we); end
    total++; if (o_req_ready !== 1'b1) begin bad++; $display("FAIL rw_async_ready got=%0b exp=1", o_req_ready); end
    total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL rw_async_valid got=%0b exp=0", o_resp_valid); end
    total++; if (o_resp_err !== 1'b0) begin bad++; $display("FAIL rw_async_err got=%0b exp=0", o_resp_err); end
    total++; if (o_resp_rdata !== 32'h0) begin bad++; $display("FAIL rw_async_rdata got=%h exp=0", o_resp_rdata); end
    total++; if (o_mem_addr !== 64'h0) begin bad++; $display("FAIL rw_async_addr got=%h exp=0", o_mem_addr); end
    total++; if (o_mem_wdata !== 32'h0) begin bad++; $display("FAIL rw_async_wdata got=%h exp=0", o_mem_wdata); end
    @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;
    total++; if (we_cnt - w0 !== 0) begin bad++; $display("FAIL rw_we_pulses got=%0d exp=0", we_cnt - w0); end
    total++; if (mem[4] !== 32'h11AA3344) begin bad++; $display("FAIL rw_mem got=%h exp=11aa3344", mem[4]); end
    @(negedge clk);
    total++; if (o_resp_valid !== 1'b0) begin bad++; $display("FAIL rw_discarded got=%0b exp=0", o_resp_valid); end
    send(1'b0, 2'b10, 1'b0, 64'h10, 32'h0, lat);
    total++; if (o_resp_rdata !== 32'h11AA3344) begin bad++; $display("FAIL rw_reload got=%h exp=11aa3344", o_resp_rdata); end
    complete();
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    arstn          = 1'b0;
    mem_clr        = 1'b1;
    i_req_valid    = 1'b0;
    i_req_we       = 1'b0;
    i_req_size     = 2'b00;
    i_req_unsigned = 1'b0;
    i_req_addr     = '0;
    i_req_wdata    = '0;
    i_resp_ready   = 1'b0;
    test_reset();
    test_word_store_load();
    test_byte_store();
    test_loads();
    test_errors();
    test_resp_hold();
    test_back_to_back();
    test_reset_in_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
